// File: rtl/aes_i2s_tx.sv
// I2S master transmitter: divides sclk into aes_bclk, frames 64 bit clocks per
// stereo pair (left in lrck-low half, one-bit delay) and shifts samples out MSB first.
module aes_i2s_tx #(
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int DATA_W    = 24
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              aes_bclk,
  output logic              aes_lrck,
  output logic              aes_sdata,
  output logic [5:0]        bit_cnt,
  output logic              underrun
);

  // Handshake: a pair moves into the holding register on a cycle where
  // din_valid && din_ready; din_ready is simply "holding register empty".

  localparam logic [7:0] DIV_TC   = 8'(SCLK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'(2 * SLOT_BITS - 1);
  localparam logic [5:0] HALF     = 6'(SLOT_BITS);

  logic [7:0]        div_cnt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic [DATA_W-1:0] act_l, act_r;

  logic              tc, fall, frame_load, accept;
  logic [5:0]        bit_nxt;
  logic [4:0]        pos;
  logic [DATA_W-1:0] ch_word, ch_shift;
  logic              sdata_nxt, lrck_nxt;

  assign din_ready = ~hold_full;

  always_comb begin
    tc         = (div_cnt == DIV_TC);
    fall       = tc && aes_bclk;
    frame_load = fall && (bit_cnt == LAST_BIT);
    accept     = din_valid && !hold_full;
    bit_nxt    = bit_cnt + 6'd1;
    pos        = bit_nxt[4:0];
    lrck_nxt   = (bit_nxt >= HALF);
    ch_word    = lrck_nxt ? act_r : act_l;
    // Slot position p selects sample bit DATA_W-p; shifting left by p-1 brings it to the MSB.
    ch_shift   = ch_word << (pos - 5'd1);
    sdata_nxt  = (pos != 5'd0) && (int'(pos) <= DATA_W) && ch_shift[DATA_W-1];
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      aes_bclk  <= 1'b0;
      aes_lrck  <= 1'b1;
      aes_sdata <= 1'b0;
      bit_cnt   <= LAST_BIT;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
    end else if (!en) begin
      div_cnt   <= '0;
      aes_bclk  <= 1'b0;
      aes_lrck  <= 1'b1;
      aes_sdata <= 1'b0;
      bit_cnt   <= LAST_BIT;
      underrun  <= 1'b0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
    end else begin
      underrun <= 1'b0;
      if (tc) begin
        div_cnt  <= '0;
        aes_bclk <= ~aes_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      // Data and lrck change only on falling bclk so they are stable at the receiver's rising edge.
      if (fall) begin
        bit_cnt   <= bit_nxt;
        aes_lrck  <= lrck_nxt;
        aes_sdata <= sdata_nxt;
      end
      if (frame_load) begin
        if (hold_full) begin
          act_l <= hold_l;
          act_r <= hold_r;
        end else begin
          act_l    <= '0;
          act_r    <= '0;
          underrun <= 1'b1;
        end
      end
      // An accept can only happen while empty, so it never collides with a full-holding load.
      if (accept) begin
        hold_l    <= l_data;
        hold_r    <= r_data;
        hold_full <= 1'b1;
      end else if (frame_load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_i2s_tx.sv
// Bench for aes_i2s_tx: transaction model of frame loads plus a receiver-style
// monitor that rebuilds each frame from the serial pins and scores it.
module tb_aes_i2s_tx;
  localparam int DIV   = 2;
  localparam int W     = 24;
  localparam int FRAME = 128 * DIV;

  logic         sclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] l_data = '0;
  logic [W-1:0] r_data = '0;
  logic         din_ready, aes_bclk, aes_lrck, aes_sdata, underrun;
  logic [5:0]   bit_cnt;

  logic         en1 = 1'b0;
  logic         din_valid1 = 1'b0;
  logic [W-1:0] l1 = '0;
  logic [W-1:0] r1 = '0;
  logic         din_ready1, bclk1, lrck1, sdata1, underrun1;
  logic [5:0]   bit_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_seen = 0;

  // reference model state
  int             n;
  logic           m_full, acc_last, und_exp, rdy_exp;
  logic [W-1:0]   m_l, m_r;
  logic [2*W-1:0] exp_q[$];

  aes_i2s_tx #(.SCLK_DIV(DIV), .SLOT_BITS(32), .DATA_W(W)) u_dut (
    .sclk(sclk), .rst_n(rst_n), .en(en), .l_data(l_data), .r_data(r_data),
    .din_valid(din_valid), .din_ready(din_ready), .aes_bclk(aes_bclk),
    .aes_lrck(aes_lrck), .aes_sdata(aes_sdata), .bit_cnt(bit_cnt), .underrun(underrun)
  );

  aes_i2s_tx #(.SCLK_DIV(1), .SLOT_BITS(32), .DATA_W(W)) u_dut1 (
    .sclk(sclk), .rst_n(rst_n), .en(en1), .l_data(l1), .r_data(r1),
    .din_valid(din_valid1), .din_ready(din_ready1), .aes_bclk(bclk1),
    .aes_lrck(lrck1), .aes_sdata(sdata1), .bit_cnt(bit_cnt1), .underrun(underrun1)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/none, expected event at %0t", name, $time);
  endtask

  // Expected {bclk, lrck, bit_cnt} after n enabled sclk edges.
  function automatic logic [7:0] exp_timing(input int nn);
    int b;
    if (nn < 2 * DIV) b = 63;
    else b = ((nn / (2 * DIV)) - 1) % 64;
    return {1'((nn / DIV) % 2), 1'(b >= 32), 6'(b)};
  endfunction

  // Decode a received 64-bit frame: {pad_nonzero, left, right}.
  function automatic logic [2*W:0] decode(input logic [63:0] b);
    logic [W-1:0] l, r;
    logic pad;
    l = '0; r = '0; pad = 1'b0;
    for (int p = 0; p < 32; p++) begin
      if (p >= 1 && p <= W) begin
        l[W-p] = b[p];
        r[W-p] = b[32+p];
      end else begin
        pad = pad | b[p] | b[32+p];
      end
    end
    return {pad, l, r};
  endfunction

  // Model: frames load every 128*DIV enabled edges starting at edge 2*DIV.
  initial begin
    logic acc;
    n = 0; m_full = 1'b0; m_l = '0; m_r = '0;
    acc_last = 1'b0; und_exp = 1'b0; rdy_exp = 1'b1;
    forever begin
      @(posedge sclk);
      acc_last = 1'b0;
      und_exp  = 1'b0;
      if (!rst_n || !en) begin
        n = 0;
        m_full = 1'b0;
        exp_q.delete();
      end else begin
        acc = din_valid && !m_full;
        n++;
        if (n % FRAME == 2 * DIV) begin
          if (m_full) exp_q.push_back({m_l, m_r});
          else begin
            exp_q.push_back('0);
            und_exp = 1'b1;
          end
          m_full = 1'b0;
        end
        if (acc) begin
          m_l = l_data;
          m_r = r_data;
          m_full = 1'b1;
          acc_last = 1'b1;
        end
      end
      rdy_exp = !m_full;
    end
  end

  // Monitor: per-cycle pin checks plus a receiver counter keyed on lrck falling.
  initial begin
    logic prev_bclk, prev_lrck, rc_ok;
    int rc;
    logic [63:0] bits;
    logic [2*W:0] dec;
    logic [2*W-1:0] want;
    logic [7:0] t;
    prev_bclk = 1'b0; prev_lrck = 1'b1; rc_ok = 1'b0; rc = 0; bits = '0;
    forever begin
      @(posedge sclk);
      #2;
      if (rst_n) begin
        t = exp_timing(n);
        check("bclk", 64'(aes_bclk), 64'(t[7]));
        check("lrck", 64'(aes_lrck), 64'(t[6]));
        check("bit_cnt", 64'(bit_cnt), 64'(t[5:0]));
        check("din_ready", 64'(din_ready), 64'(rdy_exp));
        check("underrun", 64'(underrun), 64'(und_exp));
        if (n == 0) check("idle_sdata", 64'(aes_sdata), 64'd0);
      end
      if (!en || !rst_n) begin
        prev_bclk = 1'b0;
        prev_lrck = 1'b1;
        rc_ok = 1'b0;
      end else begin
        if (aes_bclk && !prev_bclk) begin
          if (prev_lrck && !aes_lrck) begin
            rc = 0;
            rc_ok = 1'b1;
          end else begin
            rc++;
          end
          prev_lrck = aes_lrck;
          if (rc_ok && rc < 64) begin
            check("rx_cnt", 64'(bit_cnt), 64'(rc));
            bits[rc] = aes_sdata;
            if (rc == 63) begin
              dec = decode(bits);
              check("pad_zero", 64'(dec[2*W]), 64'd0);
              if (exp_q.size() == 0) fail_now("frame_expected");
              else begin
                want = exp_q.pop_front();
                check("frame_left", 64'(dec[2*W-1:W]), 64'(want[2*W-1:W]));
                check("frame_right", 64'(dec[W-1:0]), 64'(want[W-1:0]));
              end
              frames_seen++;
            end
          end
        end
        prev_bclk = aes_bclk;
      end
    end
  end

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    int guard;
    guard = 0;
    l_data = l;
    r_data = r;
    din_valid = 1'b1;
    do begin
      @(negedge sclk);
      guard++;
    end while (!acc_last && guard < 4 * FRAME);
    if (!acc_last) fail_now("accept_timeout");
    din_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int guard;
    guard = 0;
    while (n % FRAME != ph && guard < 4 * FRAME) begin
      @(negedge sclk);
      guard++;
    end
    if (n % FRAME != ph) fail_now("phase_timeout");
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [63:0]  bits1;
    logic [2*W:0] dec1;
    int rc1, cyc, last_rise, per_bad, cnt_bad;
    logic pb, pl;

    rst_n = 1'b0;
    repeat (5) @(negedge sclk);
    rst_n = 1'b1;
    repeat (100) @(negedge sclk);

    // directed pair ahead of the first frame, then an underrun frame
    en = 1'b1;
    send_pair(24'hA50F3C, 24'h800001);
    repeat (FRAME + 50) @(negedge sclk);
    send_pair(W'($urandom), W'($urandom));
    repeat (FRAME) @(negedge sclk);

    // back-pressure: valid held with an incrementing pattern
    pat = W'($urandom);
    l_data = pat;
    r_data = ~pat;
    din_valid = 1'b1;
    repeat (8 * FRAME) begin
      @(negedge sclk);
      if (acc_last) begin
        pat = pat + 1'b1;
        l_data = pat;
        r_data = ~pat;
      end
    end
    din_valid = 1'b0;
    repeat (FRAME + 10) @(negedge sclk);

    // accept on the very edge that loads a frame
    wait_phase(2 * DIV - 1);
    send_pair(W'($urandom), W'($urandom));
    repeat (2 * FRAME) @(negedge sclk);

    // drop enable at bit 40 with the holding register full
    wait_phase(2 * DIV + 10);
    send_pair(W'($urandom), W'($urandom));
    wait_phase(82 * DIV);
    check("bit_cnt_at_drop", 64'(bit_cnt), 64'd40);
    check("ready_full_at_drop", 64'(din_ready), 64'd0);
    en = 1'b0;
    @(negedge sclk);
    check("drop_bclk", 64'(aes_bclk), 64'd0);
    check("drop_lrck", 64'(aes_lrck), 64'd1);
    check("drop_bit_cnt", 64'(bit_cnt), 64'd63);
    check("drop_sdata", 64'(aes_sdata), 64'd0);
    check("drop_ready", 64'(din_ready), 64'd1);
    repeat (20) @(negedge sclk);
    en = 1'b1;
    repeat (FRAME + 50) @(negedge sclk);
    send_pair(W'($urandom), W'($urandom));
    repeat (2 * FRAME) @(negedge sclk);
    en = 1'b0;
    repeat (5) @(negedge sclk);

    // SCLK_DIV=1 instance: one frame at a 2-cycle bclk period
    l1 = W'($urandom);
    r1 = W'($urandom);
    din_valid1 = 1'b1;
    en1 = 1'b1;
    @(negedge sclk);
    din_valid1 = 1'b0;
    bits1 = '0; rc1 = -1; cyc = 0; last_rise = -1; per_bad = 0; cnt_bad = 0;
    pb = 1'b0; pl = 1'b1;
    repeat (400) begin
      @(posedge sclk);
      #2;
      cyc++;
      if (bclk1 && !pb) begin
        if (last_rise >= 0 && cyc - last_rise != 2) per_bad++;
        last_rise = cyc;
        if (pl && !lrck1) rc1 = 0;
        else if (rc1 >= 0) rc1++;
        pl = lrck1;
        if (rc1 >= 0 && rc1 < 64) begin
          bits1[rc1] = sdata1;
          if (int'(bit_cnt1) != rc1) cnt_bad++;
        end
      end
      pb = bclk1;
      if (rc1 == 63) break;
    end
    if (rc1 != 63) fail_now("div1_frame_timeout");
    dec1 = decode(bits1);
    check("div1_period_errors", 64'(per_bad), 64'd0);
    check("div1_bit_cnt_errors", 64'(cnt_bad), 64'd0);
    check("div1_pad", 64'(dec1[2*W]), 64'd0);
    check("div1_left", 64'(dec1[2*W-1:W]), 64'(l1));
    check("div1_right", 64'(dec1[W-1:0]), 64'(r1));
    en1 = 1'b0;
    repeat (5) @(negedge sclk);

    n_checks++;
    if (frames_seen < 12) begin
      n_fail++;
      $display("FAIL frames_seen: got %0d, expected at least 12", frames_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
